// File: rtl/muldiv_if.sv
// muldiv_if: start/busy/done handshake and operand/result bus of the multiply/divide engine
interface muldiv_if #(parameter int WIDTH = 32);
  logic start;
  logic [1:0] op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic abort;
  logic busy;
  logic done;
  logic div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master(output start, op, a, b, abort, input busy, done, div_zero, hi, lo);
  modport slave(input start, op, a, b, abort, output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative radix-2 MULT/MULTU/DIV/DIVU engine with start/busy/done handshake and abort
module muldiv_seq #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input logic clk,
  input logic reset,
  muldiv_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [1:0] opr;
  logic sa, sb;
  logic [WIDTH-1:0] mb;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0] rem;
  logic na, nb, sgn;
  logic [WIDTH-1:0] ma_in, mb_in, quo, rmd;
  logic [WIDTH:0] msum;
  logic [WIDTH+1:0] partial, diff;
  logic [2*WIDTH-1:0] prod;
  // Operands are kept as magnitudes; signs are reapplied in FIX.
  always_comb begin
    na = ~bus.op[0] & bus.a[WIDTH-1];
    nb = ~bus.op[0] & bus.b[WIDTH-1];
    ma_in = na ? -bus.a : bus.a;
    mb_in = nb ? -bus.b : bus.b;
    sgn = ~opr[0];
    msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mb} : '0);
    partial = {rem, acc[WIDTH-1]};
    diff = partial - {2'b00, mb};
    prod = (sgn && (sa ^ sb)) ? -acc : acc;
    quo = (sgn && (sa ^ sb)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rmd = (sgn && sa) ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      opr <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      mb <= '0;
      acc <= '0;
      rem <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.div_zero <= 1'b0;
      bus.hi <= '0;
      bus.lo <= '0;
    end else begin
      bus.done <= 1'b0;
      bus.div_zero <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          opr <= bus.op;
          sa <= na;
          sb <= nb;
          mb <= mb_in;
          acc <= {{WIDTH{1'b0}}, ma_in};
          rem <= '0;
          cnt <= '0;
          if (bus.op[1] && bus.b == '0) begin
            state <= DONE;
            bus.done <= 1'b1;
            bus.div_zero <= 1'b1;
          end else begin
            state <= RUN;
            bus.busy <= 1'b1;
          end
        end
        RUN: if (bus.abort) begin
          state <= IDLE;
          bus.busy <= 1'b0;
        end else begin
          // Divide shifts the quotient into acc's low half; multiply shifts the product down.
          if (opr[1]) begin
            rem <= diff[WIDTH+1] ? partial[WIDTH:0] : diff[WIDTH:0];
            acc[WIDTH-1:0] <= {acc[WIDTH-2:0], ~diff[WIDTH+1]};
          end else begin
            acc <= {msum, acc[WIDTH-1:1]};
          end
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: if (bus.abort) begin
          state <= IDLE;
          bus.busy <= 1'b0;
        end else begin
          {bus.hi, bus.lo} <= opr[1] ? {rmd, quo} : prod;
          state <= DONE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vectors with literal expectations plus a cycle-level arithmetic reference model
module tb_muldiv_seq;
  localparam int W = 32;
  logic clk = 1'b0;
  logic reset = 1'b0;
  muldiv_if #(.WIDTH(W)) bus();
  muldiv_seq #(.WIDTH(W)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  bit live = 1'b0;
  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask
  function automatic logic [63:0] ref_calc(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'd0: res = sa * sb;
      2'd1: res = {32'd0, a} * {32'd0, b};
      2'd2: begin
        q = sa / sb;
        r = sa % sb;
        res = {r[31:0], q[31:0]};
      end
      default: res = {a % b, a / b};
    endcase
    return res;
  endfunction
  logic m_busy, m_done, m_dz;
  logic [W-1:0] m_hi, m_lo, r_hi, r_lo;
  int left;
  // Reference: an accepted op stays busy W+1 cycles, then pulses done with the arithmetic result.
  always @(posedge clk) begin
    if (!reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_dz <= 1'b0;
      m_hi <= '0;
      m_lo <= '0;
      left <= 0;
    end else begin
      m_done <= 1'b0;
      m_dz <= 1'b0;
      if (m_busy) begin
        if (bus.abort) m_busy <= 1'b0;
        else if (left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_hi <= r_hi;
          m_lo <= r_lo;
        end
        left <= left - 1;
      end else if (!m_done && bus.start) begin
        if (bus.op[1] && bus.b == '0) begin
          m_done <= 1'b1;
          m_dz <= 1'b1;
        end else begin
          m_busy <= 1'b1;
          left <= W + 1;
          {r_hi, r_lo} <= ref_calc(bus.op, bus.a, bus.b);
        end
      end
    end
  end
  always @(negedge clk) begin
    if (live) begin
      chk("cmp_busy", bus.busy, m_busy);
      chk("cmp_done", bus.done, m_done);
      chk("cmp_div_zero", bus.div_zero, m_dz);
      chk("cmp_hi", bus.hi, m_hi);
      chk("cmp_lo", bus.lo, m_lo);
    end
  end
  task automatic run_op(string name, logic [1:0] op, logic [31:0] a, logic [31:0] b,
                        int exp_lat, logic [31:0] exp_hi, logic [31:0] exp_lo, logic exp_dz);
    int lat;
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_lat"}, lat, exp_lat);
    chk({name, "_hi"}, bus.hi, exp_hi);
    chk({name, "_lo"}, bus.lo, exp_lo);
    chk({name, "_dz"}, bus.div_zero, exp_dz);
    @(negedge clk);
  endtask
  initial begin
    #1000000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1);
  end
  initial begin
    int lat;
    bit seen;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.op = 2'd0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(negedge clk);
    live = 1'b1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    reset = 1'b1;
    @(negedge clk);
    // reset in the middle of a MULT
    bus.start = 1'b1;
    bus.op = 2'd0;
    bus.a = 32'hFFFFFFFE;
    bus.b = 32'h3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_hi", bus.hi, 0);
    chk("midrst_lo", bus.lo, 0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    chk("midrst_no_done", seen, 0);
    run_op("mult_neg", 2'd0, 32'hFFFFFFFE, 32'h3, 34, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
    run_op("multu", 2'd1, 32'hFFFFFFFE, 32'h3, 34, 32'h00000002, 32'hFFFFFFFA, 1'b0);
    run_op("mult_minmin", 2'd0, 32'h80000000, 32'h80000000, 34, 32'h40000000, 32'h0, 1'b0);
    run_op("multu_max", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("div_neg", 2'd2, 32'hFFFFFFF9, 32'h2, 34, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("divu", 2'd3, 32'd7, 32'd2, 34, 32'd1, 32'd3, 1'b0);
    run_op("div_negb", 2'd2, 32'd100, 32'hFFFFFFF9, 34, 32'd2, 32'hFFFFFFF2, 1'b0);
    run_op("div_both", 2'd2, 32'hFFFFFF9C, 32'hFFFFFFF9, 34, 32'hFFFFFFFE, 32'd14, 1'b0);
    run_op("div_ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF, 34, 32'h0, 32'h80000000, 1'b0);
    bus.abort = 1'b1;
    run_op("divu_zero", 2'd3, 32'd5, 32'd0, 1, 32'h0, 32'h80000000, 1'b1);
    bus.abort = 1'b0;
    run_op("div_zero", 2'd2, 32'hFFFFFFF9, 32'd0, 1, 32'h0, 32'h80000000, 1'b1);
    // start while busy and in the done cycle is ignored
    bus.start = 1'b1;
    bus.op = 2'd0;
    bus.a = 32'h1234;
    bus.b = 32'h100;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.op = 2'd3;
    bus.a = 32'd9;
    bus.b = 32'd0;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 6;
    while (!bus.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("busy_start_lat", lat, 34);
    chk("busy_start_hi", bus.hi, 32'h0);
    chk("busy_start_lo", bus.lo, 32'h00123400);
    chk("busy_start_dz", bus.div_zero, 0);
    bus.start = 1'b1;
    bus.op = 2'd1;
    bus.a = 32'hFFFFFFFF;
    bus.b = 32'hFFFFFFFF;
    @(negedge clk);
    chk("done_cycle_start_ignored", bus.busy, 0);
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("next_accept_lat", lat, 34);
    chk("next_accept_hi", bus.hi, 32'hFFFFFFFE);
    chk("next_accept_lo", bus.lo, 32'h00000001);
    @(negedge clk);
    // abort a DIV mid-flight, then a MULT right after
    bus.start = 1'b1;
    bus.op = 2'd2;
    bus.a = 32'd100;
    bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_hi", bus.hi, 32'hFFFFFFFE);
    chk("abort_lo", bus.lo, 32'h00000001);
    run_op("post_abort_mult", 2'd0, 32'hFFFFFFFE, 32'h3, 34, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
